// File: rtl/ahb_resp_mux_tmo.sv
// ahb_resp_mux_tmo: AHB slave-to-master response mux with default-slave ERROR and wait-state watchdog
module ahb_resp_mux_tmo #(
  parameter int NUM_SLAVES = 4,
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_WIDTH = 8,
  localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              Hclk,
  input  logic                              Hreset,
  input  logic [1:0]                        Htrans,
  input  logic [NUM_SLAVES-1:0]             slave_select,
  input  logic [MW-1:0]                     Hmaster,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  Hrdata_S,
  input  logic [NUM_SLAVES*2-1:0]           Hresp_S,
  input  logic [NUM_SLAVES-1:0]             Hreadyout_S,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] Hrdata,
  output logic [NUM_MASTERS*2-1:0]          Hresp,
  output logic                              Hready,
  output logic                              timeout_err,
  output logic [CNT_WIDTH-1:0]              err_count
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state;
  logic [NUM_SLAVES-1:0] dp_sel;
  logic [MW-1:0] dp_master, hm;
  logic [WW-1:0] wait_cnt;
  logic err_cause;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [1:0] sel_resp;
  logic sel_ready, active, onehot, sample, tmo_hit, err_go;
  assign hm = NUM_MASTERS == 1 ? '0 : Hmaster;
  assign active = Htrans inside {2'b10, 2'b11};
  assign onehot = |slave_select && !(|(slave_select & (slave_select - 1'b1)));
  assign sample = state != ERR1 && Hready;
  assign tmo_hit = TIMEOUT > 0 && state == DATA && !sel_ready && wait_cnt == TMO_LAST;
  assign err_go = (sample && active && !onehot) || tmo_hit;
  // dp_sel is one-hot whenever it is used, so an OR-reduction acts as the mux
  always_comb begin
    sel_rdata = '0;
    sel_resp = '0;
    sel_ready = 1'b0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      sel_rdata |= dp_sel[s] ? Hrdata_S[s*DATA_WIDTH +: DATA_WIDTH] : '0;
      sel_resp |= dp_sel[s] ? Hresp_S[s*2 +: 2] : 2'b00;
      sel_ready |= dp_sel[s] & Hreadyout_S[s];
    end
  end
  always_comb begin
    Hready = state == DATA ? sel_ready : state != ERR1;
    timeout_err = state == ERR1 && err_cause;
    Hrdata = '0;
    Hresp = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (dp_master == MW'(m)) begin
        Hrdata[m*DATA_WIDTH +: DATA_WIDTH] = state == DATA ? sel_rdata : '0;
        Hresp[m*2 +: 2] = state == DATA ? sel_resp : (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
      end
    end
  end
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state <= IDLE;
      dp_sel <= '0;
      dp_master <= '0;
      wait_cnt <= '0;
      err_cause <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == ERR1) state <= ERR2;
      else if (sample) begin
        state <= !active ? IDLE : onehot ? DATA : ERR1;
        if (active) dp_master <= hm;
        if (active && onehot) begin
          dp_sel <= slave_select;
          wait_cnt <= '0;
        end
        if (active && !onehot) err_cause <= 1'b0;
      end else if (tmo_hit) begin
        state <= ERR1;
        err_cause <= 1'b1;
      end else if (state == DATA && TIMEOUT > 0) wait_cnt <= wait_cnt + 1'b1;
      if (err_go && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: doc/ahb_resp_mux_tmo.md
Name: ahb_resp_mux_tmo

Overview:
Parametrised AHB slave-to-master response multiplexer with a built-in default slave and a wait-state watchdog. It registers the decoded slave and owning master at each accepted address phase. During the data phase it routes that slave's HRDATA/HRESP to the owning master and drives the global Hready. It generates the two-cycle ERROR response for unmapped or illegal decodes and for slaves that stall longer than TIMEOUT cycles. It sits between the slave array and the master ports, fed by the address decoder and arbiter.

Parameters:
NUM_SLAVES, 4, number of slave ports (>=1)
NUM_MASTERS, 2, number of master ports (>=1)
DATA_WIDTH, 32, read data width
TIMEOUT, 16, max consecutive data-phase wait cycles before forced ERROR; 0 disables watchdog
CNT_WIDTH, 8, width of error event counter

Ports:
Hclk  in  1  bus clock
Hreset  in  1  asynchronous, active-high reset
Htrans  in  2  address-phase HTRANS of granted master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
slave_select  in  NUM_SLAVES  address-phase one-hot decode from decoder
Hmaster  in  MW=max(1,$clog2(NUM_MASTERS))  address-phase granted master index
Hrdata_S  in  [NUM_SLAVES] x DATA_WIDTH  slave read data
Hresp_S  in  [NUM_SLAVES] x 2  slave response (00 OKAY, 01 ERROR)
Hreadyout_S  in  [NUM_SLAVES] x 1  slave ready
Hrdata  out  [NUM_MASTERS] x DATA_WIDTH  per-master read data
Hresp  out  [NUM_MASTERS] x 2  per-master response
Hready  out  1  global HREADY to masters and slaves
timeout_err  out  1  high during ERR1 cycle caused by watchdog
err_count  out  CNT_WIDTH  saturating count of ERR1 entries

Behaviour:
- Reset (async, Hreset=1): state IDLE, dp_sel=0, dp_master=0, wait_cnt=0, err_count=0, err_cause=0.
- Outputs during reset: Hready=1, all Hrdata=0, all Hresp=OKAY, timeout_err=0.
- State machine: IDLE, DATA, ERR1, ERR2.
- Address-phase sample: occurs on any rising edge with Hready=1, in states IDLE, DATA or ERR2.
  - Htrans[1]=0: go to IDLE.
  - Htrans[1]=1 and slave_select exactly one-hot: go to DATA; latch dp_sel=slave_select, dp_master=Hmaster; clear wait_cnt.
  - Htrans[1]=1 and slave_select zero or multi-hot: go to ERR1; latch dp_master=Hmaster; err_cause=decode.
- IDLE outputs: Hready=1, Resp OKAY, Rdata 0 to all masters.
- DATA routing (i = index of dp_sel), combinational from registered select; zero added latency versus slave outputs:
  - Hready=Hreadyout_S[i].
  - Hrdata[dp_master]=Hrdata_S[i], Hresp[dp_master]=Hresp_S[i].
  - All other masters: Rdata 0, Resp OKAY.
  - Slave ERROR is passed through unmodified; the slave sequences its own two cycles.
- Watchdog (TIMEOUT>0), in DATA:
  - wait_cnt increments each cycle Hreadyout_S[i]=0; clears when it is 1.
  - When wait_cnt==TIMEOUT-1 and Hreadyout_S[i]=0: next state ERR1, err_cause=timeout.
  - Result: TIMEOUT wait cycles are passed through before forcing.
  - The slave is not aborted; it sees Hready pulse high in ERR2, and later slave outputs are ignored.
- ERR1: Hready=0, Hresp[dp_master]=ERROR, Hrdata=0; timeout_err=(err_cause==timeout). Next state ERR2 unconditionally.
- ERR2: Hready=1, Hresp[dp_master]=ERROR, Hrdata=0. The address phase is sampled this edge per the rules above.
- err_count: +1 on every entry into ERR1; saturates at all-ones with no wrap.
- dp_master >= NUM_MASTERS: no master receives data or resp (all 0/OKAY); Hready and state behaviour unchanged.
- NUM_MASTERS=1: Hmaster is ignored; master 0 always owns.
- Simultaneous timeout threshold and slave ready the same cycle: ready wins, transfer completes normally.
- Reset asserted mid-transfer: immediate return to reset values regardless of state.

Test Plan:
- Reset then idle: assert Hreset 3 cycles, release, Htrans=00 -> Hready=1, Hresp all 00, Hrdata all 0, err_count=0.
- Zero-wait read: master 1 NONSEQ, slave_select=0100, slave 2 Hrdata=0xCAFE0001, Hreadyout=1 -> next cycle Hrdata[1]=0xCAFE0001, Hresp[1]=00, Hready=1, Hrdata[0]=0.
- Unmapped decode: NONSEQ with slave_select=0000, then 0011 -> each gives ERR1 (Hready=0, Hresp=01) then ERR2 (Hready=1, Hresp=01); err_count=2, timeout_err stays 0.
- Watchdog with TIMEOUT=4: slave 0 holds Hreadyout=0 -> Hready=0 for 4 DATA cycles, then ERR1 with timeout_err=1, then ERR2; err_count=1.
- Ready at threshold: slave raises Hreadyout exactly on wait cycle 4 -> OKAY completion, no ERR1, err_count unchanged.
- Saturation and async reset: CNT_WIDTH=2, force 5 decode errors -> err_count=3. Assert Hreset mid-DATA -> outputs return to reset values without a clock edge.
